// File: rtl/serial_transmitter.sv
// UART-style transmitter: one-byte holding register feeding an LSB-first
// start/data/stop shifter, each bit held CLKS_PER_BIT clocks on a registered line.
module serial_transmitter #(
  parameter int CLKS_PER_BIT = 16,
  parameter int DATA_BITS    = 8
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 load,
  input  logic [DATA_BITS-1:0] data_in,
  output logic                 ready,
  output logic                 data_out,
  output logic                 busy,
  output logic                 charSent
);

  localparam int SW = $clog2(CLKS_PER_BIT);
  localparam int BW = $clog2(DATA_BITS + 1);
  localparam logic [SW-1:0] SAMP_LAST = SW'(CLKS_PER_BIT - 1);
  localparam logic [BW-1:0] BIT_LAST  = BW'(DATA_BITS - 1);

  typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

  state_t               state_q, state_d;
  logic [DATA_BITS-1:0] hold_q, hold_d;
  logic                 hold_full_q, hold_full_d;
  logic [DATA_BITS-1:0] shift_q, shift_d;
  logic [SW-1:0]        samp_q, samp_d;
  logic [BW-1:0]        bit_q, bit_d;
  logic                 data_out_q, data_out_d;
  logic                 charsent_q, charsent_d;
  logic                 bit_end;

  assign bit_end = (samp_q == SAMP_LAST);

  always_comb begin
    state_d     = state_q;
    hold_d      = hold_q;
    hold_full_d = hold_full_q;
    shift_d     = shift_q;
    samp_d      = samp_q;
    bit_d       = bit_q;
    charsent_d  = 1'b0;

    if (load && !hold_full_q) begin
      hold_d      = data_in;
      hold_full_d = 1'b1;
    end

    // Transfers out of the holding register only happen while it is full,
    // so they never collide with a same-cycle load.
    case (state_q)
      IDLE: begin
        samp_d = '0;
        if (hold_full_q) begin
          shift_d     = hold_q;
          hold_full_d = 1'b0;
          state_d     = START;
        end
      end
      START: begin
        if (bit_end) begin
          samp_d  = '0;
          bit_d   = '0;
          state_d = DATA;
        end else begin
          samp_d = samp_q + 1'b1;
        end
      end
      DATA: begin
        if (bit_end) begin
          samp_d  = '0;
          shift_d = shift_q >> 1;
          if (bit_q == BIT_LAST) begin
            state_d = STOP;
          end else begin
            bit_d = bit_q + 1'b1;
          end
        end else begin
          samp_d = samp_q + 1'b1;
        end
      end
      STOP: begin
        if (bit_end) begin
          samp_d     = '0;
          charsent_d = 1'b1;
          if (hold_full_q) begin
            shift_d     = hold_q;
            hold_full_d = 1'b0;
            state_d     = START;
          end else begin
            state_d = IDLE;
          end
        end else begin
          samp_d = samp_q + 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase

    // Line level is a function of the next state so it can be registered.
    case (state_d)
      START:   data_out_d = 1'b0;
      DATA:    data_out_d = shift_d[0];
      default: data_out_d = 1'b1;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q     <= IDLE;
      hold_q      <= '0;
      hold_full_q <= 1'b0;
      shift_q     <= '0;
      samp_q      <= '0;
      bit_q       <= '0;
      data_out_q  <= 1'b1;
      charsent_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      hold_q      <= hold_d;
      hold_full_q <= hold_full_d;
      shift_q     <= shift_d;
      samp_q      <= samp_d;
      bit_q       <= bit_d;
      data_out_q  <= data_out_d;
      charsent_q  <= charsent_d;
    end
  end

  assign ready    = ~hold_full_q;
  assign busy     = (state_q != IDLE);
  assign data_out = data_out_q;
  assign charSent = charsent_q;

endmodule

// File: tb/tb_serial_transmitter.sv
// Directed bench for serial_transmitter: reset, single frame, back-to-back,
// overrun protection and mid-frame reset, each bit checked every clock.
module tb_serial_transmitter;

  logic       clk;
  logic       reset;
  logic       load;
  logic [7:0] data_in;
  logic       ready;
  logic       data_out;
  logic       busy;
  logic       charSent;

  int n_cmp = 0;
  int n_err = 0;
  int cyc   = 0;
  int t1, t2;

  serial_transmitter #(.CLKS_PER_BIT(16), .DATA_BITS(8)) dut (
    .clk      (clk),
    .reset    (reset),
    .load     (load),
    .data_in  (data_in),
    .ready    (ready),
    .data_out (data_out),
    .busy     (busy),
    .charSent (charSent)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Checks frame cycles j0..j1-1, where cycle 0 is the first start-bit clock.
  task automatic frame(input logic [7:0] b, input int j0, input int j1);
    logic [9:0] bits;
    bits = {1'b1, b, 1'b0};
    for (int j = j0; j < j1; j++) begin
      chk("frame_line", {31'd0, data_out}, {31'd0, bits[j/16]});
      chk("frame_busy", {31'd0, busy}, 32'd1);
      if (j > 0) chk("frame_nocs", {31'd0, charSent}, 32'd0);
      tick();
    end
  endtask

  task automatic idle_check(input string tag, input int n);
    for (int i = 0; i < n; i++) begin
      tick();
      chk(tag, {29'd0, data_out, busy, charSent}, 32'b100);
    end
  endtask

  initial begin
    reset   = 1'b0;
    load    = 1'b0;
    data_in = 8'h00;
    tick();

    // Reset held: load toggling must have no effect
    for (int i = 0; i < 6; i++) begin
      load    = i[0];
      data_in = 8'hFF;
      tick();
      chk("rst_outs", {28'd0, data_out, ready, busy, charSent}, 32'b1100);
    end
    load  = 1'b0;
    reset = 1'b1;
    idle_check("post_rst_idle", 20);
    chk("post_rst_ready", {31'd0, ready}, 32'd1);

    // Single frame 8'hA5
    load = 1'b1; data_in = 8'hA5;
    tick();
    load = 1'b0;
    chk("a5_ready_low", {31'd0, ready}, 32'd0);
    chk("a5_line_idle", {31'd0, data_out}, 32'd1);
    tick();
    frame(8'hA5, 0, 160);
    chk("a5_cs", {31'd0, charSent}, 32'd1);
    chk("a5_end", {29'd0, data_out, ready, busy}, 32'b110);
    tick();
    chk("a5_cs_once", {31'd0, charSent}, 32'd0);
    idle_check("a5_after_idle", 5);

    // Back-to-back 8'h01 then 8'h80
    load = 1'b1; data_in = 8'h01;
    tick();
    load = 1'b0;
    tick();
    chk("b2b_ready_up", {31'd0, ready}, 32'd1);
    frame(8'h01, 0, 1);
    load = 1'b1; data_in = 8'h80;
    frame(8'h01, 1, 2);
    load = 1'b0;
    chk("b2b_ready_low", {31'd0, ready}, 32'd0);
    frame(8'h01, 2, 160);
    chk("b2b_cs1", {31'd0, charSent}, 32'd1);
    chk("b2b_no_gap", {29'd0, data_out, ready, busy}, 32'b011);
    t1 = cyc;
    frame(8'h80, 0, 160);
    chk("b2b_cs2", {31'd0, charSent}, 32'd1);
    chk("b2b_end_busy", {31'd0, busy}, 32'd0);
    t2 = cyc;
    chk("b2b_cs_gap", t2 - t1, 32'd160);
    idle_check("b2b_after_idle", 5);

    // Overrun: 8'h55 offered while 8'h96 is held must be ignored
    load = 1'b1; data_in = 8'h11;
    tick();
    load = 1'b0;
    tick();
    frame(8'h11, 0, 1);
    load = 1'b1; data_in = 8'h96;
    frame(8'h11, 1, 2);
    load = 1'b0;
    frame(8'h11, 2, 50);
    load = 1'b1; data_in = 8'h55;
    chk("ovr_ready_low", {31'd0, ready}, 32'd0);
    frame(8'h11, 50, 53);
    load = 1'b0;
    chk("ovr_ready_still", {31'd0, ready}, 32'd0);
    frame(8'h11, 53, 160);
    chk("ovr_cs1", {31'd0, charSent}, 32'd1);
    chk("ovr_ready_up", {31'd0, ready}, 32'd1);
    frame(8'h96, 0, 160);
    chk("ovr_cs2", {31'd0, charSent}, 32'd1);
    chk("ovr_end_busy", {31'd0, busy}, 32'd0);
    idle_check("ovr_after_idle", 5);

    // Reset during data bit 3 of 8'hC3
    load = 1'b1; data_in = 8'hC3;
    tick();
    load = 1'b0;
    tick();
    frame(8'hC3, 0, 16 + 3*16 + 5);
    chk("mid_line_low", {31'd0, data_out}, 32'd0);
    reset = 1'b0;
    #1;
    chk("mid_rst_async", {28'd0, data_out, ready, busy, charSent}, 32'b1100);
    tick();
    tick();
    reset = 1'b1;
    idle_check("mid_after_idle", 30);
    chk("mid_ready", {31'd0, ready}, 32'd1);
    load = 1'b1; data_in = 8'h3C;
    tick();
    load = 1'b0;
    tick();
    frame(8'h3C, 0, 160);
    chk("mid_3c_cs", {31'd0, charSent}, 32'd1);
    chk("mid_3c_end", {29'd0, data_out, ready, busy}, 32'b110);
    tick();
    chk("mid_3c_cs_once", {31'd0, charSent}, 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
